game_ctrl_fsm: RTL and testbench

GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

---
 rtl/game_ctrl_fsm.sv | 161 ++++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_fsm.sv
// rtl/game_ctrl_fsm.sv - game flow controller: start, countdown, game, game over, lives and flap pulses
// Optional pause state (right click) is built when GAME_PAUSE_EN is defined.
module game_ctrl_fsm #(
    parameter int LIVES             = 3,
    parameter int COUNTDOWN_CYC     = 65_000_000,
    parameter int GAMEOVER_HOLD_CYC = 32_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mouse_left,
    input  logic       mouse_right,
    input  logic       collision,
    output logic [2:0] state,
    output logic       game_rst,
    output logic       mouse_left_game,
    output logic [3:0] lives
);

    localparam int MAX_CYC = (COUNTDOWN_CYC > GAMEOVER_HOLD_CYC) ? COUNTDOWN_CYC : GAMEOVER_HOLD_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] CD_LOAD = TW'(COUNTDOWN_CYC - 1);
    localparam logic [TW-1:0] GO_LOAD = TW'(GAMEOVER_HOLD_CYC);

    typedef enum logic [2:0] {
        S_START     = 3'b000,
        S_COUNTDOWN = 3'b001,
        S_GAME      = 3'b010,
        S_PAUSE     = 3'b011,
        S_GAMEOVER  = 3'b100
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    lives_q, lives_d;
    logic          game_rst_q, game_rst_d;
    logic          flap_q, flap_d;

    // Inputs are registered once, then compared against their previous value.
    logic ml_q, ml_prev, col_q, armed;
    logic left_edge;

    assign left_edge = armed & ml_q & ~ml_prev;

`ifdef GAME_PAUSE_EN
    logic mr_q, mr_prev;
    logic right_edge;

    assign right_edge = armed & mr_q & ~mr_prev;
`else
    logic unused_right;

    assign unused_right = mouse_right;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ml_q    <= 1'b0;
            ml_prev <= 1'b0;
            col_q   <= 1'b0;
            armed   <= 1'b0;
`ifdef GAME_PAUSE_EN
            mr_q    <= 1'b0;
            mr_prev <= 1'b0;
`endif
        end else begin
            col_q <= collision;
            ml_q  <= mouse_left;
            armed <= 1'b1;
            // First edge after reset primes both stages so a held button is not an edge.
            ml_prev <= armed ? ml_q : mouse_left;
`ifdef GAME_PAUSE_EN
            mr_q    <= mouse_right;
            mr_prev <= armed ? mr_q : mouse_right;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = (timer_q != '0) ? timer_q - 1'b1 : '0;
        lives_d    = lives_q;
        game_rst_d = 1'b0;
        flap_d     = 1'b0;
        case (state_q)
            S_START: begin
                if (left_edge) begin
                    state_d    = S_COUNTDOWN;
                    timer_d    = CD_LOAD;
                    lives_d    = 4'(LIVES);
                    game_rst_d = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (timer_q == '0) begin
                    state_d = S_GAME;
                end
            end
            S_GAME: begin
                if (col_q) begin
                    if (lives_q > 4'd1) begin
                        lives_d    = lives_q - 4'd1;
                        game_rst_d = 1'b1;
                        state_d    = S_COUNTDOWN;
                        timer_d    = CD_LOAD;
                    end else begin
                        lives_d = 4'd0;
                        state_d = S_GAMEOVER;
                        timer_d = GO_LOAD;
                    end
`ifdef GAME_PAUSE_EN
                end else if (right_edge) begin
                    state_d = S_PAUSE;
`endif
                end else if (left_edge) begin
                    flap_d = 1'b1;
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (right_edge) begin
                    state_d = S_COUNTDOWN;
                    timer_d = CD_LOAD;
                end
            end
`endif
            S_GAMEOVER: begin
                if (timer_q == '0 && left_edge) begin
                    state_d    = S_START;
                    game_rst_d = 1'b1;
                end
            end
            default: begin
                state_d = S_START;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_START;
            timer_q    <= '0;
            lives_q    <= 4'(LIVES);
            game_rst_q <= 1'b0;
            flap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lives_q    <= lives_d;
            game_rst_q <= game_rst_d;
            flap_q     <= flap_d;
        end
    end

    assign state           = state_q;
    assign game_rst        = game_rst_q;
    assign mouse_left_game = flap_q;
    assign lives           = lives_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb/tb_game_ctrl_fsm.sv - directed/randomized bench for game_ctrl_fsm (LIVES=2, COUNTDOWN_CYC=4, GAMEOVER_HOLD_CYC=3)
module tb_game_ctrl_fsm;

    localparam int L  = 2;
    localparam int CD = 4;
    localparam int GO = 3;

    localparam logic [2:0] ST_START = 3'b000;
    localparam logic [2:0] ST_CD    = 3'b001;
    localparam logic [2:0] ST_GAME  = 3'b010;
    localparam logic [2:0] ST_PAUSE = 3'b011;
    localparam logic [2:0] ST_GO    = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mouse_left = 1'b0;
    logic       mouse_right = 1'b0;
    logic       collision = 1'b0;
    logic [2:0] state;
    logic       game_rst;
    logic       mouse_left_game;
    logic [3:0] lives;

    int tests = 0;
    int fails = 0;

    game_ctrl_fsm #(
        .LIVES            (L),
        .COUNTDOWN_CYC    (CD),
        .GAMEOVER_HOLD_CYC(GO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mouse_left     (mouse_left),
        .mouse_right    (mouse_right),
        .collision      (collision),
        .state          (state),
        .game_rst       (game_rst),
        .mouse_left_game(mouse_left_game),
        .lives          (lives)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1);
    end

    // game_rst and the flap pulse must never coincide.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            assert (!(game_rst && mouse_left_game)) else begin
                fails++;
                $error("FAIL pulse_excl: observed both high, expected at most one");
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_left();
        mouse_left = 1'b1;
        tick();
        mouse_left = 1'b0;
    endtask

    task automatic pulse_right();
        mouse_right = 1'b1;
        tick();
        mouse_right = 1'b0;
    endtask

    // Called in the first countdown cycle; random clicks early in the countdown must be ignored.
    task automatic run_countdown(input string tag, input int exp_rst);
        int n_cd   = 0;
        int n_rst  = 0;
        int n_flap = 0;
        for (int i = 0; i < 64 && state == ST_CD; i++) begin
            n_cd++;
            n_rst  += int'(game_rst);
            n_flap += int'(mouse_left_game);
            mouse_left = (n_cd < CD - 2) ? 1'($urandom % 2) : 1'b0;
            tick();
        end
        mouse_left = 1'b0;
        check({tag, "_cd_len"}, n_cd, CD);
        check({tag, "_cd_rst"}, n_rst, exp_rst);
        check({tag, "_cd_flap"}, n_flap, 0);
        check({tag, "_to_game"}, state, ST_GAME);
    endtask

    initial begin
        int n_flaps;
        int cnt;
        int hold;

        // Button held through reset release must not start a game.
        mouse_left = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, ST_START);
        check("rst_grst", game_rst, 0);
        check("rst_flap", mouse_left_game, 0);
        check("rst_lives", lives, L);
        rst = 1'b0;
        repeat (4) tick();
        check("held_state", state, ST_START);
        mouse_left = 1'b0;
        repeat (2) tick();
        check("held_release_state", state, ST_START);

        pulse_left();
        tick();
        check("start_grst", game_rst, 1);
        check("start_state", state, ST_CD);
        check("start_lives", lives, L);
        run_countdown("start", 1);

        n_flaps = 3 + int'($urandom % 3);
        cnt = 0;
        for (int k = 0; k < n_flaps; k++) begin
            pulse_left();
            tick();
            check("flap_latency", mouse_left_game, 1);
            cnt += int'(mouse_left_game);
            tick();
            check("flap_width", mouse_left_game, 0);
            repeat ($urandom % 3) tick();
        end
        check("flap_count", cnt, n_flaps);

        hold = 3 + int'($urandom % 4);
        cnt = 0;
        mouse_left = 1'b1;
        repeat (hold) begin
            tick();
            cnt += int'(mouse_left_game);
        end
        mouse_left = 1'b0;
        repeat (3) begin
            tick();
            cnt += int'(mouse_left_game);
        end
        check("held_one_flap", cnt, 1);
        check("game_state", state, ST_GAME);
        check("game_lives", lives, L);

`ifdef GAME_PAUSE_EN
        pulse_right();
        tick();
        check("pause_enter", state, ST_PAUSE);
        collision = 1'b1;
        pulse_left();
        repeat (4) tick();
        check("pause_hold_state", state, ST_PAUSE);
        check("pause_hold_lives", lives, L);
        check("pause_no_flap", mouse_left_game, 0);
        collision = 1'b0;
        repeat (2) tick();
        pulse_right();
        tick();
        check("pause_exit_state", state, ST_CD);
        check("pause_exit_lives", lives, L);
        check("pause_exit_grst", game_rst, 0);
        run_countdown("pause", 0);
`else
        pulse_right();
        repeat (2) tick();
        check("right_ignored", state, ST_GAME);
`endif

        // Collision and click together: collision wins.
        collision  = 1'b1;
        mouse_left = 1'b1;
        tick();
        collision  = 1'b0;
        mouse_left = 1'b0;
        tick();
        check("col1_flap", mouse_left_game, 0);
        check("col1_lives", lives, L - 1);
        check("col1_grst", game_rst, 1);
        check("col1_state", state, ST_CD);
        run_countdown("col1", 1);

        collision = 1'b1;
        tick();
        collision = 1'b0;
        tick();
        check("col2_state", state, ST_GO);
        check("col2_lives", lives, 0);
        check("col2_grst", game_rst, 0);

        pulse_left();
        tick();
        check("go_early_state", state, ST_GO);
        check("go_early_grst", game_rst, 0);
        repeat (GO + 1) tick();
        pulse_left();
        tick();
        check("go_exit_state", state, ST_START);
        check("go_exit_grst", game_rst, 1);
        tick();
        check("go_exit_grst_w", game_rst, 0);
        check("go_exit_lives", lives, 0);

        // Async reset mid-countdown, then a full countdown from START.
        pulse_left();
        tick();
        check("restart_lives", lives, L);
        check("restart_grst", game_rst, 1);
        rst = 1'b1;
        #1;
        check("async_rst_state", state, ST_START);
        check("async_rst_grst", game_rst, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("post_rst_state", state, ST_START);
        pulse_left();
        tick();
        check("post_rst_cd", state, ST_CD);
        run_countdown("post_rst", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
